// File: rtl/mc_control_unit_if.sv
// Control-unit <-> datapath bundle: decoded instruction fields in, strobes and mux selects out.
// Latency: pure wiring; timing is set by whoever drives each side.
// Backpressure: none; memory stalls are modelled by the control unit's MEM_WAIT wait states.
interface mc_control_unit_if #(
  parameter int CNT_W = 32
);
  // Instruction fields and ALU status supplied by the datapath
  logic [5:0]       op;
  logic [5:0]       Funct;
  logic             Zero;

  // Strobes and mux selects driven by the control unit
  logic             PCen;
  logic             IorD;
  logic             Ori;
  logic             MemWrite;
  logic             IRWrite;
  logic             RegDst;
  logic             MemtoReg;
  logic             RegWrite;
  logic             ALUSrcA;
  logic             PCsrc;
  logic [1:0]       ALUSrcB;
  logic [2:0]       ALUControl;

  // Status
  logic             illegal_o;
  logic [CNT_W-1:0] instr_cnt_o;

  // Control-unit side
  modport master (
    input  op, Funct, Zero,
    output PCen, IorD, Ori, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
           ALUSrcA, PCsrc, ALUSrcB, ALUControl, illegal_o, instr_cnt_o
  );

  // Datapath side
  modport slave (
    output op, Funct, Zero,
    input  PCen, IorD, Ori, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
           ALUSrcA, PCsrc, ALUSrcB, ALUControl, illegal_o, instr_cnt_o
  );
endinterface

// File: rtl/mc_control_unit.sv
// Multicycle MIPS-style control FSM with memory wait states, sticky illegal trap and retire counter.
// Latency (W = MEM_WAIT): R/imm W+4, lw 2W+5, sw 2W+4, beq/bne W+3 cycles; outputs are combinational from state.
// Backpressure: none; FETCH/MEMRD/MEMWR dwell W+1 cycles. Optional bne support: define MC_CTRL_BNE_EN.
module mc_control_unit #(
  parameter int MEM_WAIT = 0,   // 0..15
  parameter int CNT_W    = 32
) (
  input  logic             clk,
  input  logic             reset,
  mc_control_unit_if.master bus
);

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_ALUWB,
    S_MEMADR,
    S_MEMRD,
    S_MEMWB,
    S_MEMWR,
    S_IEXEC,
    S_IWB,
    S_BRANCH,
    S_TRAP
  } state_t;

  localparam logic [3:0] LP_WAIT = 4'(MEM_WAIT);

  localparam logic [5:0] LP_OP_RTYPE = 6'b000000;
  localparam logic [5:0] LP_OP_LW    = 6'b100011;
  localparam logic [5:0] LP_OP_SW    = 6'b101011;
  localparam logic [5:0] LP_OP_BEQ   = 6'b000100;
  localparam logic [5:0] LP_OP_ADDI  = 6'b001000;
  localparam logic [5:0] LP_OP_ORI   = 6'b001101;
  localparam logic [5:0] LP_OP_IN    = 6'b111111;
`ifdef MC_CTRL_BNE_EN
  localparam logic [5:0] LP_OP_BNE   = 6'b000101;
`else
`endif

  localparam logic [5:0] LP_FN_ADD = 6'b100000;
  localparam logic [5:0] LP_FN_SUB = 6'b100010;
  localparam logic [5:0] LP_FN_AND = 6'b100100;
  localparam logic [5:0] LP_FN_OR  = 6'b100101;
  localparam logic [5:0] LP_FN_SLT = 6'b101010;

  localparam logic [2:0] LP_ALU_AND = 3'b000;
  localparam logic [2:0] LP_ALU_OR  = 3'b001;
  localparam logic [2:0] LP_ALU_ADD = 3'b010;
  localparam logic [2:0] LP_ALU_SUB = 3'b110;
  localparam logic [2:0] LP_ALU_SLT = 3'b111;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [3:0]       r_wait_cnt;
  logic             r_illegal;
  logic [CNT_W-1:0] r_instr_cnt;

  logic             w_wait_done;
  logic             w_mem_state;
  logic             w_retire;
  logic             w_funct_ok;
  logic [2:0]       w_funct_alu;

  logic             w_pc_en;
  logic             w_iord;
  logic             w_ori;
  logic             w_mem_write;
  logic             w_ir_write;
  logic             w_reg_dst;
  logic             w_mem_to_reg;
  logic             w_reg_write;
  logic             w_alu_src_a;
  logic             w_pc_src;
  logic [1:0]       w_alu_src_b;
  logic [2:0]       w_alu_ctl;

  // Final cycle of a memory-facing state: the only cycle its strobe may fire
  assign w_wait_done = (r_wait_cnt == LP_WAIT);
  assign w_mem_state = (r_state == S_FETCH) || (r_state == S_MEMRD) || (r_state == S_MEMWR);

  // R-type function decode; unknown Funct values are flagged so EXEC can trap
  always_comb begin
    w_funct_ok  = 1'b1;
    w_funct_alu = LP_ALU_ADD;
    case (bus.Funct)
      LP_FN_ADD: w_funct_alu = LP_ALU_ADD;
      LP_FN_SUB: w_funct_alu = LP_ALU_SUB;
      LP_FN_AND: w_funct_alu = LP_ALU_AND;
      LP_FN_OR:  w_funct_alu = LP_ALU_OR;
      LP_FN_SLT: w_funct_alu = LP_ALU_SLT;
      default: begin
        w_funct_ok  = 1'b0;
        w_funct_alu = LP_ALU_AND;
      end
    endcase
  end

  // Next-state and datapath control decode; everything defaults to 0 / stay
  always_comb begin
    w_state_nxt  = r_state;
    w_retire     = 1'b0;
    w_pc_en      = 1'b0;
    w_iord       = 1'b0;
    w_ori        = 1'b0;
    w_mem_write  = 1'b0;
    w_ir_write   = 1'b0;
    w_reg_dst    = 1'b0;
    w_mem_to_reg = 1'b0;
    w_reg_write  = 1'b0;
    w_alu_src_a  = 1'b0;
    w_pc_src     = 1'b0;
    w_alu_src_b  = 2'b00;
    w_alu_ctl    = LP_ALU_AND;

    case (r_state)
      S_FETCH: begin
        // PC + 4 computed every cycle; only the last wait cycle latches IR and PC
        w_alu_src_b = 2'b01;
        w_alu_ctl   = LP_ALU_ADD;
        if (w_wait_done) begin
          w_pc_en     = 1'b1;
          w_ir_write  = 1'b1;
          w_state_nxt = S_DECODE;
        end
      end

      S_DECODE: begin
        // Speculative branch target PC + (SignImm << 2) lands in ALU_o
        w_alu_src_b = 2'b11;
        w_alu_ctl   = LP_ALU_ADD;
        case (bus.op)
          LP_OP_RTYPE:          w_state_nxt = S_EXEC;
          LP_OP_LW, LP_OP_SW:   w_state_nxt = S_MEMADR;
          LP_OP_BEQ:            w_state_nxt = S_BRANCH;
`ifdef MC_CTRL_BNE_EN
          LP_OP_BNE:            w_state_nxt = S_BRANCH;
`else
`endif
          LP_OP_ADDI, LP_OP_ORI,
          LP_OP_IN:             w_state_nxt = S_IEXEC;
          default:              w_state_nxt = S_TRAP;
        endcase
      end

      S_EXEC: begin
        w_alu_src_a = 1'b1;
        w_alu_src_b = 2'b00;
        w_alu_ctl   = w_funct_alu;
        w_state_nxt = w_funct_ok ? S_ALUWB : S_TRAP;
      end

      S_ALUWB: begin
        w_reg_dst   = 1'b1;
        w_reg_write = 1'b1;
        w_retire    = 1'b1;
        w_state_nxt = S_FETCH;
      end

      S_MEMADR: begin
        w_alu_src_a = 1'b1;
        w_alu_src_b = 2'b10;
        w_alu_ctl   = LP_ALU_ADD;
        w_state_nxt = (bus.op == LP_OP_LW) ? S_MEMRD : S_MEMWR;
      end

      S_MEMRD: begin
        // Address held on ALU_o for the whole access
        w_iord = 1'b1;
        if (w_wait_done) begin
          w_state_nxt = S_MEMWB;
        end
      end

      S_MEMWB: begin
        w_iord       = 1'b1;
        w_mem_to_reg = 1'b1;
        w_reg_write  = 1'b1;
        w_retire     = 1'b1;
        w_state_nxt  = S_FETCH;
      end

      S_MEMWR: begin
        w_iord = 1'b1;
        if (w_wait_done) begin
          w_mem_write = 1'b1;
          w_retire    = 1'b1;
          w_state_nxt = S_FETCH;
        end
      end

      S_IEXEC: begin
        // IN reuses the addi path with the immediate taken from GPIO
        w_alu_src_a = 1'b1;
        w_alu_src_b = 2'b10;
        w_alu_ctl   = (bus.op == LP_OP_ORI) ? LP_ALU_OR : LP_ALU_ADD;
        w_ori       = (bus.op == LP_OP_IN);
        w_state_nxt = S_IWB;
      end

      S_IWB: begin
        // Ori kept so the GPIO-derived value stays selected through write-back
        w_ori       = (bus.op == LP_OP_IN);
        w_reg_write = 1'b1;
        w_retire    = 1'b1;
        w_state_nxt = S_FETCH;
      end

      S_BRANCH: begin
        w_alu_src_a = 1'b1;
        w_alu_src_b = 2'b00;
        w_alu_ctl   = LP_ALU_SUB;
        w_pc_src    = 1'b1;
`ifdef MC_CTRL_BNE_EN
        w_pc_en     = (bus.op == LP_OP_BNE) ? ~bus.Zero : bus.Zero;
`else
        w_pc_en     = bus.Zero;
`endif
        w_retire    = 1'b1;
        w_state_nxt = S_FETCH;
      end

      S_TRAP: begin
        // Parked until reset; all controls stay at their defaults
        w_state_nxt = S_TRAP;
      end

      default: begin
        w_state_nxt = S_FETCH;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_FETCH;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Wait-state counter: runs 0..MEM_WAIT inside memory states, cleared elsewhere
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wait_cnt <= 4'd0;
    end else if (w_mem_state && !w_wait_done) begin
      r_wait_cnt <= r_wait_cnt + 4'd1;
    end else begin
      r_wait_cnt <= 4'd0;
    end
  end

  // Sticky trap flag, raised as the FSM enters TRAP
  always_ff @(posedge clk) begin
    if (reset) begin
      r_illegal <= 1'b0;
    end else if (w_state_nxt == S_TRAP) begin
      r_illegal <= 1'b1;
    end
  end

  // Retired-instruction counter, wraps naturally at 2^CNT_W
  always_ff @(posedge clk) begin
    if (reset) begin
      r_instr_cnt <= '0;
    end else if (w_retire) begin
      r_instr_cnt <= r_instr_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  // Architectural-state strobes are suppressed during reset so an abandoned instruction leaves no trace
  assign bus.PCen        = w_pc_en     & ~reset;
  assign bus.IRWrite     = w_ir_write  & ~reset;
  assign bus.MemWrite    = w_mem_write & ~reset;
  assign bus.RegWrite    = w_reg_write & ~reset;
  assign bus.IorD        = w_iord;
  assign bus.Ori         = w_ori;
  assign bus.RegDst      = w_reg_dst;
  assign bus.MemtoReg    = w_mem_to_reg;
  assign bus.ALUSrcA     = w_alu_src_a;
  assign bus.PCsrc       = w_pc_src;
  assign bus.ALUSrcB     = w_alu_src_b;
  assign bus.ALUControl  = w_alu_ctl;
  assign bus.illegal_o   = r_illegal;
  assign bus.instr_cnt_o = r_instr_cnt;

endmodule

// File: tb/tb_mc_control_unit.sv
// Directed bench for mc_control_unit: three instances (MEM_WAIT 0, 2, 3) driven from per-cycle vector tables.
// Output word packing: {PCen,IorD,Ori,MemWrite,IRWrite, RegDst,MemtoReg,RegWrite, ALUSrcA,PCsrc, ALUSrcB, ALUControl}.
// Hand-written sequences cover trap, illegal Funct, reset release and the optional bne opcode.
module tb_mc_control_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a = 1'b1;
  logic rst_b = 1'b1;
  logic rst_c = 1'b1;

  mc_control_unit_if #(.CNT_W(32)) ifa ();
  mc_control_unit_if #(.CNT_W(32)) ifb ();
  mc_control_unit_if #(.CNT_W(32)) ifc ();

  mc_control_unit #(.MEM_WAIT(0), .CNT_W(32)) u_a (.clk(clk), .reset(rst_a), .bus(ifa));
  mc_control_unit #(.MEM_WAIT(2), .CNT_W(32)) u_b (.clk(clk), .reset(rst_b), .bus(ifb));
  mc_control_unit #(.MEM_WAIT(3), .CNT_W(32)) u_c (.clk(clk), .reset(rst_c), .bus(ifc));

  logic [14:0] out_a, out_b, out_c;
  assign out_a = {ifa.PCen, ifa.IorD, ifa.Ori, ifa.MemWrite, ifa.IRWrite, ifa.RegDst, ifa.MemtoReg,
                  ifa.RegWrite, ifa.ALUSrcA, ifa.PCsrc, ifa.ALUSrcB, ifa.ALUControl};
  assign out_b = {ifb.PCen, ifb.IorD, ifb.Ori, ifb.MemWrite, ifb.IRWrite, ifb.RegDst, ifb.MemtoReg,
                  ifb.RegWrite, ifb.ALUSrcA, ifb.PCsrc, ifb.ALUSrcB, ifb.ALUControl};
  assign out_c = {ifc.PCen, ifc.IorD, ifc.Ori, ifc.MemWrite, ifc.IRWrite, ifc.RegDst, ifc.MemtoReg,
                  ifc.RegWrite, ifc.ALUSrcA, ifc.PCsrc, ifc.ALUSrcB, ifc.ALUControl};

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_IN   = 6'b111111;
  localparam logic [5:0] OP_BAD  = 6'b010101;

  localparam logic [5:0] F_ADD = 6'b100000;
  localparam logic [5:0] F_SUB = 6'b100010;
  localparam logic [5:0] F_AND = 6'b100100;
  localparam logic [5:0] F_OR  = 6'b100101;
  localparam logic [5:0] F_SLT = 6'b101010;

  // Hand-computed output words
  localparam logic [14:0] O_FETCH  = 15'b10001_000_00_01_010; // final fetch cycle
  localparam logic [14:0] O_FWAIT  = 15'b00000_000_00_01_010; // fetch wait cycle / fetch under reset
  localparam logic [14:0] O_DEC    = 15'b00000_000_00_11_010;
  localparam logic [14:0] O_ALUWB  = 15'b00000_101_00_00_000;
  localparam logic [14:0] O_IWB    = 15'b00000_001_00_00_000;
  localparam logic [14:0] O_MEMADR = 15'b00000_000_10_10_010;
  localparam logic [14:0] O_MEMRD  = 15'b01000_000_00_00_000;
  localparam logic [14:0] O_MEMWB  = 15'b01000_011_00_00_000;
  localparam logic [14:0] O_MEMWR  = 15'b01010_000_00_00_000;
  localparam logic [14:0] O_BR_T   = 15'b10000_000_11_00_110;
  localparam logic [14:0] O_BR_N   = 15'b00000_000_11_00_110;
  localparam logic [14:0] M_STROBE = 15'b10011_001_00_00_000;

  typedef struct {
    logic        rst;
    logic [5:0]  op;
    logic [5:0]  funct;
    logic        zero;
    logic [14:0] exp_out;
    logic        exp_ill;
    logic [31:0] exp_cnt;
  } vec_t;

  vec_t va[$];
  vec_t vb[$];
  vec_t vc[$];

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s[%0d] got=%h want=%h", nm, idx, act, exp);
    end
  endtask

  task automatic add(input int sel, input logic r, input logic [5:0] op, input logic [5:0] fn,
                     input logic z, input logic [14:0] o, input logic il, input logic [31:0] c);
    vec_t e;
    e.rst = r; e.op = op; e.funct = fn; e.zero = z;
    e.exp_out = o; e.exp_ill = il; e.exp_cnt = c;
    case (sel)
      0:       va.push_back(e);
      1:       vb.push_back(e);
      default: vc.push_back(e);
    endcase
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Apply one vector per cycle: drive just after posedge, compare at negedge
  task automatic run_table(input int sel, input string nm, input vec_t v[$]);
    logic [14:0] o;
    logic        il;
    logic [31:0] c;
    for (int i = 0; i < v.size(); i++) begin
      case (sel)
        0: begin rst_a = v[i].rst; ifa.op = v[i].op; ifa.Funct = v[i].funct; ifa.Zero = v[i].zero; end
        1: begin rst_b = v[i].rst; ifb.op = v[i].op; ifb.Funct = v[i].funct; ifb.Zero = v[i].zero; end
        default: begin rst_c = v[i].rst; ifc.op = v[i].op; ifc.Funct = v[i].funct; ifc.Zero = v[i].zero; end
      endcase
      @(negedge clk);
      case (sel)
        0:       begin o = out_a; il = ifa.illegal_o; c = ifa.instr_cnt_o; end
        1:       begin o = out_b; il = ifb.illegal_o; c = ifb.instr_cnt_o; end
        default: begin o = out_c; il = ifc.illegal_o; c = ifc.instr_cnt_o; end
      endcase
      chk({nm, ".out"}, i, {17'd0, o}, {17'd0, v[i].exp_out});
      chk({nm, ".ill"}, i, {31'd0, il}, {31'd0, v[i].exp_ill});
      chk({nm, ".cnt"}, i, c, v[i].exp_cnt);
      tick();
    end
  endtask

  initial begin
    ifa.op = OP_R; ifa.Funct = F_ADD; ifa.Zero = 1'b0;
    ifb.op = OP_R; ifb.Funct = F_ADD; ifb.Zero = 1'b0;
    ifc.op = OP_R; ifc.Funct = F_ADD; ifc.Zero = 1'b0;

    // ---- Table A: MEM_WAIT = 0, every instruction class back to back ----
    add(0, 0, OP_R, F_SUB, 1, O_FETCH, 0, 0);
    add(0, 0, OP_R, F_SUB, 1, O_DEC, 0, 0);
    add(0, 0, OP_R, F_SUB, 1, 15'b00000_000_10_00_110, 0, 0);
    add(0, 0, OP_R, F_SUB, 1, O_ALUWB, 0, 0);
    add(0, 0, OP_ADDI, 6'd0, 1, O_FETCH, 0, 1);
    add(0, 0, OP_ADDI, 6'd0, 1, O_DEC, 0, 1);
    add(0, 0, OP_ADDI, 6'd0, 1, 15'b00000_000_10_10_010, 0, 1);
    add(0, 0, OP_ADDI, 6'd0, 1, O_IWB, 0, 1);
    add(0, 0, OP_ORI, 6'd0, 0, O_FETCH, 0, 2);
    add(0, 0, OP_ORI, 6'd0, 0, O_DEC, 0, 2);
    add(0, 0, OP_ORI, 6'd0, 0, 15'b00000_000_10_10_001, 0, 2);
    add(0, 0, OP_ORI, 6'd0, 0, O_IWB, 0, 2);
    add(0, 0, OP_IN, 6'd0, 0, O_FETCH, 0, 3);
    add(0, 0, OP_IN, 6'd0, 0, O_DEC, 0, 3);
    add(0, 0, OP_IN, 6'd0, 0, 15'b00100_000_10_10_010, 0, 3);
    add(0, 0, OP_IN, 6'd0, 0, 15'b00100_001_00_00_000, 0, 3);
    add(0, 0, OP_BEQ, 6'd0, 1, O_FETCH, 0, 4);
    add(0, 0, OP_BEQ, 6'd0, 1, O_DEC, 0, 4);
    add(0, 0, OP_BEQ, 6'd0, 1, O_BR_T, 0, 4);
    add(0, 0, OP_BEQ, 6'd0, 0, O_FETCH, 0, 5);
    add(0, 0, OP_BEQ, 6'd0, 0, O_DEC, 0, 5);
    add(0, 0, OP_BEQ, 6'd0, 0, O_BR_N, 0, 5);
    add(0, 0, OP_R, F_AND, 0, O_FETCH, 0, 6);
    add(0, 0, OP_R, F_AND, 0, O_DEC, 0, 6);
    add(0, 0, OP_R, F_AND, 0, 15'b00000_000_10_00_000, 0, 6);
    add(0, 0, OP_R, F_AND, 0, O_ALUWB, 0, 6);
    add(0, 0, OP_R, F_OR, 0, O_FETCH, 0, 7);
    add(0, 0, OP_R, F_OR, 0, O_DEC, 0, 7);
    add(0, 0, OP_R, F_OR, 0, 15'b00000_000_10_00_001, 0, 7);
    add(0, 0, OP_R, F_OR, 0, O_ALUWB, 0, 7);
    add(0, 0, OP_R, F_SLT, 0, O_FETCH, 0, 8);
    add(0, 0, OP_R, F_SLT, 0, O_DEC, 0, 8);
    add(0, 0, OP_R, F_SLT, 0, 15'b00000_000_10_00_111, 0, 8);
    add(0, 0, OP_R, F_SLT, 0, O_ALUWB, 0, 8);
    add(0, 0, OP_R, F_ADD, 0, O_FETCH, 0, 9);
    add(0, 0, OP_R, F_ADD, 0, O_DEC, 0, 9);
    add(0, 0, OP_R, F_ADD, 0, 15'b00000_000_10_00_010, 0, 9);
    add(0, 0, OP_R, F_ADD, 0, O_ALUWB, 0, 9);
    add(0, 0, OP_LW, 6'd0, 0, O_FETCH, 0, 10);
    add(0, 0, OP_LW, 6'd0, 0, O_DEC, 0, 10);
    add(0, 0, OP_LW, 6'd0, 0, O_MEMADR, 0, 10);
    add(0, 0, OP_LW, 6'd0, 0, O_MEMRD, 0, 10);
    add(0, 0, OP_LW, 6'd0, 0, O_MEMWB, 0, 10);
    add(0, 0, OP_SW, 6'd0, 0, O_FETCH, 0, 11);
    add(0, 0, OP_SW, 6'd0, 0, O_DEC, 0, 11);
    add(0, 0, OP_SW, 6'd0, 0, O_MEMADR, 0, 11);
    add(0, 0, OP_SW, 6'd0, 0, O_MEMWR, 0, 11);
    add(0, 0, OP_BAD, 6'd0, 0, O_FETCH, 0, 12);

    // ---- Table B: MEM_WAIT = 2, lw takes 9 cycles ----
    add(1, 0, OP_LW, 6'd0, 0, O_FWAIT, 0, 0);
    add(1, 0, OP_LW, 6'd0, 0, O_FWAIT, 0, 0);
    add(1, 0, OP_LW, 6'd0, 0, O_FETCH, 0, 0);
    add(1, 0, OP_LW, 6'd0, 0, O_DEC, 0, 0);
    add(1, 0, OP_LW, 6'd0, 0, O_MEMADR, 0, 0);
    add(1, 0, OP_LW, 6'd0, 0, O_MEMRD, 0, 0);
    add(1, 0, OP_LW, 6'd0, 0, O_MEMRD, 0, 0);
    add(1, 0, OP_LW, 6'd0, 0, O_MEMRD, 0, 0);
    add(1, 0, OP_LW, 6'd0, 0, O_MEMWB, 0, 0);
    add(1, 0, OP_LW, 6'd0, 0, O_FWAIT, 0, 1);

    // ---- Table C: MEM_WAIT = 3, sw aborted by reset in 2nd MEMWR cycle, then a full sw ----
    add(2, 0, OP_SW, 6'd0, 0, O_FWAIT, 0, 0);
    add(2, 0, OP_SW, 6'd0, 0, O_FWAIT, 0, 0);
    add(2, 0, OP_SW, 6'd0, 0, O_FWAIT, 0, 0);
    add(2, 0, OP_SW, 6'd0, 0, O_FETCH, 0, 0);
    add(2, 0, OP_SW, 6'd0, 0, O_DEC, 0, 0);
    add(2, 0, OP_SW, 6'd0, 0, O_MEMADR, 0, 0);
    add(2, 0, OP_SW, 6'd0, 0, O_MEMRD, 0, 0);
    add(2, 1, OP_SW, 6'd0, 0, O_MEMRD, 0, 0);
    add(2, 0, OP_SW, 6'd0, 0, O_FWAIT, 0, 0);
    add(2, 0, OP_SW, 6'd0, 0, O_FWAIT, 0, 0);
    add(2, 0, OP_SW, 6'd0, 0, O_FWAIT, 0, 0);
    add(2, 0, OP_SW, 6'd0, 0, O_FETCH, 0, 0);
    add(2, 0, OP_SW, 6'd0, 0, O_DEC, 0, 0);
    add(2, 0, OP_SW, 6'd0, 0, O_MEMADR, 0, 0);
    add(2, 0, OP_SW, 6'd0, 0, O_MEMRD, 0, 0);
    add(2, 0, OP_SW, 6'd0, 0, O_MEMRD, 0, 0);
    add(2, 0, OP_SW, 6'd0, 0, O_MEMRD, 0, 0);
    add(2, 0, OP_SW, 6'd0, 0, O_MEMWR, 0, 0);
    add(2, 0, OP_SW, 6'd0, 0, O_FWAIT, 0, 1);

    // Reset held 3 cycles on A: FETCH decode visible but strobes forced low
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst.out", i, {17'd0, out_a}, {17'd0, O_FWAIT});
      chk("rst.ill", i, {31'd0, ifa.illegal_o}, 32'd0);
      chk("rst.cnt", i, ifa.instr_cnt_o, 32'd0);
      tick();
    end
    rst_a = 1'b0;

    run_table(0, "A", va);

    // Unsupported opcode: DECODE, then TRAP with all outputs low
    @(negedge clk);
    chk("trap.dec", 0, {17'd0, out_a}, {17'd0, O_DEC});
    chk("trap.ill0", 0, {31'd0, ifa.illegal_o}, 32'd0);
    tick();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("trap.out", i, {17'd0, out_a}, 32'd0);
      chk("trap.ill", i, {31'd0, ifa.illegal_o}, 32'd1);
      chk("trap.cnt", i, ifa.instr_cnt_o, 32'd12);
      tick();
    end
    rst_a = 1'b1;
    @(negedge clk);
    chk("trap.rststb", 0, {17'd0, out_a & M_STROBE}, 32'd0);
    tick();
    rst_a = 1'b0;
    @(negedge clk);
    chk("recov.out", 0, {17'd0, out_a}, {17'd0, O_FETCH});
    chk("recov.ill", 0, {31'd0, ifa.illegal_o}, 32'd0);
    chk("recov.cnt", 0, ifa.instr_cnt_o, 32'd0);

    // Unknown Funct: EXEC goes straight to TRAP, no write-back
    ifa.op = OP_R; ifa.Funct = 6'b000111;
    tick(); tick(); tick();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("badfn.out", i, {17'd0, out_a}, 32'd0);
      chk("badfn.ill", i, {31'd0, ifa.illegal_o}, 32'd1);
      chk("badfn.cnt", i, ifa.instr_cnt_o, 32'd0);
      tick();
    end

    // bne opcode: branch on ~Zero when enabled, trap otherwise
    rst_a = 1'b1;
    tick();
    rst_a = 1'b0; ifa.op = OP_BNE; ifa.Zero = 1'b0;
    @(negedge clk);
    chk("bne.fetch", 0, {17'd0, out_a}, {17'd0, O_FETCH});
    tick(); tick();
    @(negedge clk);
`ifdef MC_CTRL_BNE_EN
    chk("bne.br", 0, {17'd0, out_a}, {17'd0, O_BR_T});
    chk("bne.ill", 0, {31'd0, ifa.illegal_o}, 32'd0);
    tick();
    @(negedge clk);
    chk("bne.cnt", 0, ifa.instr_cnt_o, 32'd1);
`else
    chk("bne.trap", 0, {17'd0, out_a}, 32'd0);
    chk("bne.ill", 0, {31'd0, ifa.illegal_o}, 32'd1);
`endif
    tick();

    run_table(1, "B", vb);
    run_table(2, "C", vc);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
